// File: rtl/edge_event_sched.sv
// Multi-channel edge-event scheduler.
// Each channel synchronizes its input, detects an edge of programmable polarity,
// and latches it as a pending event. Pending events are arbitrated
// (round-robin or fixed priority) and offered one at a time over valid/ack.
// A sticky overflow bit records an edge that lands on a still-pending channel.
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_IDLE  | nothing offered; pick a pending channel when one exists
// S_OFFER | evt_valid high, evt_chan held until the consumer acks
module edge_event_sched #(
    parameter int   NCH  = 8,
    parameter int   SYNC = 2,
    parameter logic RR   = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clken,
    input  logic                   cfg_wr,
    input  logic [NCH-1:0]         cfg_pos_i,
    input  logic [NCH-1:0]         cfg_ena_i,
    input  logic [NCH-1:0]         in,
    output logic                   evt_valid,
    output logic [$clog2(NCH)-1:0] evt_chan,
    input  logic                   evt_ack,
    output logic [NCH-1:0]         pend,
    output logic [NCH-1:0]         ovfl,
    input  logic                   ovfl_clr
);
    localparam int CW = $clog2(NCH);

    typedef enum logic {S_IDLE, S_OFFER} state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [CW-1:0]   r_chan;
    logic [CW-1:0]   w_chan_nxt;
    logic [CW-1:0]   r_ptr;
    logic [CW-1:0]   w_ptr_nxt;
    logic [NCH-1:0]  r_sync [SYNC];
    logic [NCH-1:0]  r_last;
    logic [NCH-1:0]  r_pos;
    logic [NCH-1:0]  r_ena;
    logic [NCH-1:0]  r_pend;
    logic [NCH-1:0]  r_ovfl;
    logic [NCH-1:0]  w_s;
    logic [NCH-1:0]  w_edge;
    logic [NCH-1:0]  w_ack_clr;
    logic [NCH-1:0]  w_dis_clr;
    logic [NCH-1:0]  w_pend_eff;
    logic            w_any;
    logic [CW-1:0]   w_sel;

    assign w_s = r_sync[SYNC-1];

    // Edges depend only on the synchronized value and its previous sample, so
    // a polarity rewrite alone can never fabricate an event.
    assign w_edge = clken ? (r_ena & ((r_pos & w_s & ~r_last) | (~r_pos & ~w_s & r_last)))
                          : '0;

    // Synchronizer chain and last-sample register, advanced only on clken.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < SYNC; k++) r_sync[k] <= '0;
            r_last <= '0;
        end else if (clken) begin
            r_sync[0] <= in;
            for (int k = 1; k < SYNC; k++) r_sync[k] <= r_sync[k-1];
            r_last <= w_s;
        end
    end

    // Configuration registers; rising polarity and all channels off after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pos <= '1;
            r_ena <= '0;
        end else if (cfg_wr) begin
            r_pos <= cfg_pos_i;
            r_ena <= cfg_ena_i;
        end
    end

    // Clear masks: the acked channel, and channels being disabled except the
    // one currently offered (it must survive until the consumer acks it).
    always_comb begin
        w_ack_clr = '0;
        w_dis_clr = cfg_wr ? ~cfg_ena_i : '0;
        if (r_state == S_OFFER) begin
            w_dis_clr[r_chan] = 1'b0;
            if (evt_ack) w_ack_clr[r_chan] = 1'b1;
        end
    end

    // Pending set/clear and sticky overflow; an edge coinciding with its own
    // ack re-pends the channel without counting as an overflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pend <= '0;
            r_ovfl <= '0;
        end else begin
            r_pend <= ((r_pend & ~w_ack_clr) | w_edge) & ~w_dis_clr;
            r_ovfl <= (r_ovfl & {NCH{~ovfl_clr}}) | (w_edge & r_pend & ~w_ack_clr);
        end
    end

    assign w_pend_eff = r_pend & ~w_dis_clr;

    // Arbiter: scan from the highest offset down so the lowest offset wins.
    always_comb begin
        int idx;
        idx   = 0;
        w_any = 1'b0;
        w_sel = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (RR) idx = (int'(r_ptr) + i) % NCH;
            else    idx = i;
            if (w_pend_eff[idx[CW-1:0]]) begin
                w_any = 1'b1;
                w_sel = idx[CW-1:0];
            end
        end
    end

    // FSM state, offered channel and round-robin pointer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_chan  <= '0;
            r_ptr   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_chan  <= w_chan_nxt;
            r_ptr   <= w_ptr_nxt;
        end
    end

    // FSM next state: offer on any pending bit, hold until ack, then idle one clk.
    always_comb begin
        w_state_nxt = r_state;
        w_chan_nxt  = r_chan;
        w_ptr_nxt   = r_ptr;
        case (r_state)
            S_IDLE: begin
                if (w_any) begin
                    w_state_nxt = S_OFFER;
                    w_chan_nxt  = w_sel;
                end
            end
            S_OFFER: begin
                if (evt_ack) begin
                    w_state_nxt = S_IDLE;
                    if (RR) w_ptr_nxt = (r_chan == CW'(NCH - 1)) ? '0 : r_chan + 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign evt_valid = (r_state == S_OFFER);
    assign evt_chan  = r_chan;
    assign pend      = r_pend;
    assign ovfl      = r_ovfl;

endmodule

// File: tb/tb_edge_event_sched.sv
// Bench for edge_event_sched: one round-robin and one fixed-priority instance
// share the inputs but have separate acks. A behavioural model is compared
// every cycle, and directed scenarios pin hand-computed values.
module tb_edge_event_sched;
    localparam int NCH  = 8;
    localparam int SYNC = 2;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           clken = 1'b1;
    logic           cfg_wr = 1'b0;
    logic [NCH-1:0] cfg_pos = '0;
    logic [NCH-1:0] cfg_ena = '0;
    logic [NCH-1:0] in_v = '0;
    logic           ovfl_clr = 1'b0;
    logic           ack_r = 1'b0;
    logic           ack_f = 1'b0;
    logic           valid_r, valid_f;
    logic [2:0]     chan_r, chan_f;
    logic [NCH-1:0] pend_r, pend_f, ovfl_r, ovfl_f;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    edge_event_sched #(.NCH(NCH), .SYNC(SYNC), .RR(1'b1)) u_rr (
        .clk(clk), .rst(rst), .clken(clken), .cfg_wr(cfg_wr),
        .cfg_pos_i(cfg_pos), .cfg_ena_i(cfg_ena), .in(in_v),
        .evt_valid(valid_r), .evt_chan(chan_r), .evt_ack(ack_r),
        .pend(pend_r), .ovfl(ovfl_r), .ovfl_clr(ovfl_clr));

    edge_event_sched #(.NCH(NCH), .SYNC(SYNC), .RR(1'b0)) u_fp (
        .clk(clk), .rst(rst), .clken(clken), .cfg_wr(cfg_wr),
        .cfg_pos_i(cfg_pos), .cfg_ena_i(cfg_ena), .in(in_v),
        .evt_valid(valid_f), .evt_chan(chan_f), .evt_ack(ack_f),
        .pend(pend_f), .ovfl(ovfl_f), .ovfl_clr(ovfl_clr));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // hist[k] is the input as sampled k+1 clken-ticks ago; the channel sees
    // its input SYNC ticks late and compares it with the tick before that.
    logic [NCH-1:0] hist [SYNC+1];
    logic [NCH-1:0] m_pos, m_ena;
    logic [NCH-1:0] m_pend [2];
    logic [NCH-1:0] m_ovfl [2];
    logic           m_valid [2];
    int             m_chan [2];
    int             m_ptr [2];

    always @(posedge clk or posedge rst) begin
        logic [NCH-1:0] s, l, edges, clr, c, am, eff;
        logic           a;
        int             pick;
        if (rst) begin
            for (int k = 0; k <= SYNC; k++) hist[k] = '0;
            m_pos = '1;
            m_ena = '0;
            for (int j = 0; j < 2; j++) begin
                m_pend[j] = '0; m_ovfl[j] = '0; m_valid[j] = 1'b0;
                m_chan[j] = 0;  m_ptr[j] = 0;
            end
        end else begin
            s = hist[SYNC-1];
            l = hist[SYNC];
            edges = '0;
            if (clken)
                for (int n = 0; n < NCH; n++)
                    if (m_ena[n] && (m_pos[n] ? (s[n] && !l[n]) : (!s[n] && l[n]))) edges[n] = 1'b1;
            clr = cfg_wr ? ~cfg_ena : '0;
            for (int j = 0; j < 2; j++) begin
                a  = m_valid[j] && ((j == 0) ? ack_r : ack_f);
                am = '0;
                if (a) am[m_chan[j]] = 1'b1;
                c = clr;
                if (m_valid[j]) c[m_chan[j]] = 1'b0;
                eff = m_pend[j] & ~c;
                m_ovfl[j] = (ovfl_clr ? '0 : m_ovfl[j]) | (edges & m_pend[j] & ~am);
                m_pend[j] = ((m_pend[j] & ~am) | edges) & ~c;
                if (m_valid[j]) begin
                    if (a) begin
                        m_valid[j] = 1'b0;
                        if (j == 0) m_ptr[j] = (m_chan[j] + 1) % NCH;
                    end
                end else begin
                    pick = -1;
                    for (int i = 0; i < NCH; i++) begin
                        int n;
                        n = (j == 0) ? (m_ptr[j] + i) % NCH : i;
                        if (pick < 0 && eff[n]) pick = n;
                    end
                    if (pick >= 0) begin
                        m_valid[j] = 1'b1;
                        m_chan[j]  = pick;
                    end
                end
            end
            if (cfg_wr) begin
                m_pos = cfg_pos;
                m_ena = cfg_ena;
            end
            if (clken) begin
                for (int k = SYNC; k > 0; k--) hist[k] = hist[k-1];
                hist[0] = in_v;
            end
        end
    end

    // Every cycle out of reset, both instances must agree with the model.
    always @(negedge clk) begin
        if (!rst) begin
            chk("model_rr_valid", valid_r, m_valid[0]);
            chk("model_rr_pend",  pend_r,  m_pend[0]);
            chk("model_rr_ovfl",  ovfl_r,  m_ovfl[0]);
            if (m_valid[0]) chk("model_rr_chan", chan_r, m_chan[0]);
            chk("model_fp_valid", valid_f, m_valid[1]);
            chk("model_fp_pend",  pend_f,  m_pend[1]);
            chk("model_fp_ovfl",  ovfl_f,  m_ovfl[1]);
            if (m_valid[1]) chk("model_fp_chan", chan_f, m_chan[1]);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic cfg(input logic [NCH-1:0] pos, input logic [NCH-1:0] ena);
        cfg_pos = pos;
        cfg_ena = ena;
        cfg_wr  = 1'b1;
        tick(1);
        cfg_wr  = 1'b0;
    endtask

    task automatic do_reset;
        #2 rst = 1'b1;
        tick(1);
        #2 rst = 1'b0;
        tick(1);
    endtask

    task automatic wait_r(input int exp);
        int k;
        k = 0;
        while (!valid_r && k < 20) begin tick(1); k++; end
        chk("offer_rr_valid", valid_r, 1);
        chk("offer_rr_chan", chan_r, exp);
    endtask

    task automatic wait_f(input int exp);
        int k;
        k = 0;
        while (!valid_f && k < 20) begin tick(1); k++; end
        chk("offer_fp_valid", valid_f, 1);
        chk("offer_fp_chan", chan_f, exp);
    endtask

    task automatic ackr;
        ack_r = 1'b1; tick(1); ack_r = 1'b0;
    endtask

    task automatic ackf;
        ack_f = 1'b1; tick(1); ack_f = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        // reset values
        tick(2);
        chk("rst_valid", valid_r, 0);
        chk("rst_chan",  chan_r,  0);
        chk("rst_pend",  pend_r,  0);
        chk("rst_ovfl",  ovfl_r,  0);
        chk("rst_pend_fp", pend_f, 0);
        #2 rst = 1'b0;
        tick(1);

        // single event latency and ack
        cfg(8'h01, 8'h01);
        in_v = 8'h01;
        tick(2); chk("lat_pend_early", pend_r, 8'h00);
        tick(1); chk("lat_pend", pend_r, 8'h01);
        tick(1); chk("lat_valid", valid_r, 1); chk("lat_chan", chan_r, 0);
        tick(2); ack_r = 1'b1; ack_f = 1'b1;
        tick(1); ack_r = 1'b0; ack_f = 1'b0;
        chk("ack_pend", pend_r, 8'h00); chk("ack_valid", valid_r, 0);
        in_v = 8'h00;
        tick(4);

        // falling polarity on channel 3, then clken gating
        cfg(8'hF7, 8'h08);
        in_v = 8'h08;
        tick(5); chk("fall_rise_pend", pend_r, 8'h00); chk("fall_rise_valid", valid_r, 0);
        in_v = 8'h00;
        tick(3); chk("fall_pend", pend_r, 8'h08);
        tick(1); chk("fall_valid", valid_r, 1); chk("fall_chan", chan_r, 3);
        ack_r = 1'b1; ack_f = 1'b1;
        tick(1); ack_r = 1'b0; ack_f = 1'b0;
        tick(3); chk("fall_once", pend_r, 8'h00);
        clken = 1'b0;
        in_v = 8'h08; tick(4);
        in_v = 8'h00; tick(4);
        chk("clken_off_pend", pend_r, 8'h00);
        clken = 1'b1;
        tick(3); chk("clken_on_pend", pend_r, 8'h00);

        // round-robin order with wrap
        in_v = 8'h00; do_reset;
        cfg(8'hFF, 8'hFF);
        in_v = 8'hA4;
        wait_r(2); chk("rr_pend_all", pend_r, 8'hA4);
        ackr;
        wait_r(5);
        in_v = 8'hA0; tick(3);
        in_v = 8'hA4; tick(4);
        chk("rr_repend", pend_r, 8'hA4);
        ackr;
        wait_r(7); ackr;
        wait_r(2); ackr;
        tick(2); chk("rr_drain_pend", pend_r, 8'h00); chk("rr_drain_valid", valid_r, 0);

        // fixed priority with late low-index arrival
        in_v = 8'h00; do_reset;
        cfg(8'hFF, 8'hFF);
        in_v = 8'h42;
        wait_f(1);
        in_v = 8'h43; tick(4);
        chk("fp_pend", pend_f, 8'h43);
        ackf; wait_f(0);
        ackf; wait_f(6);
        ackf;
        chk("fp_drain_pend", pend_f, 8'h00);
        chk("fp_ovfl", ovfl_f, 8'h00);

        // overflow, ack coincidence, clear vs set
        in_v = 8'h00; do_reset;
        cfg(8'hFF, 8'hFF);
        in_v = 8'h10;
        wait_r(4);
        in_v = 8'h00; tick(3);
        in_v = 8'h10; tick(4);
        chk("ovf_set", ovfl_r, 8'h10); chk("ovf_pend", pend_r, 8'h10); chk("ovf_valid", valid_r, 1);
        ovfl_clr = 1'b1; tick(1); ovfl_clr = 1'b0;
        chk("ovf_clr", ovfl_r, 8'h00);
        in_v = 8'h00; tick(4);
        in_v = 8'h10; tick(2);
        ack_r = 1'b1; tick(1); ack_r = 1'b0;
        chk("ack_edge_pend", pend_r, 8'h10); chk("ack_edge_ovfl", ovfl_r, 8'h00);
        chk("ack_edge_valid", valid_r, 0);
        tick(1);
        in_v = 8'h00; tick(4);
        in_v = 8'h10; tick(2);
        ovfl_clr = 1'b1; tick(1); ovfl_clr = 1'b0;
        chk("clr_vs_set", ovfl_r, 8'h10);
        ovfl_clr = 1'b1; tick(1); ovfl_clr = 1'b0;
        chk("clr_again", ovfl_r, 8'h00);
        ackr; tick(2);

        // disable while pending/offered, then async reset mid-offer
        in_v = 8'h00; do_reset;
        cfg(8'hFF, 8'hFF);
        in_v = 8'h06;
        wait_r(1); chk("dis_pend_before", pend_r, 8'h06);
        cfg(8'hFF, 8'hF9);
        chk("dis_pend_after", pend_r, 8'h02); chk("dis_valid", valid_r, 1); chk("dis_chan", chan_r, 1);
        ackr;
        chk("dis_ack_pend", pend_r, 8'h00); chk("dis_ack_valid", valid_r, 0);
        cfg(8'hFF, 8'hFF);
        in_v = 8'h0E;
        wait_r(3);
        #2 rst = 1'b1;
        #1 chk("async_rst_valid", valid_r, 0); chk("async_rst_pend", pend_r, 8'h00);
        tick(1);
        #2 rst = 1'b0;
        tick(1);

        // power-up edge: inputs held high through reset give one event each
        cfg(8'hFF, 8'hFF);
        wait_r(1); ackr;
        wait_r(2); ackr;
        wait_r(3); ackr;
        tick(3); chk("powerup_once", pend_r, 8'h00);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/edge_event_sched.md
Name: edge_event_sched

Overview:
- Multi-channel edge-event scheduler for asynchronous console and front-panel style inputs (switches, external strobes).
- Each channel synchronizes its input and detects one edge of a configurable polarity. Each detected edge is latched as a pending event.
- Pending events are arbitrated and handed one at a time to a single consumer, such as a CSR/interrupt block, over a valid/ack handshake.
- Overflow is flagged when an edge arrives on a channel whose previous event has not been consumed.

Parameters:
- NCH, 8, number of input channels (2..32).
- SYNC, 2, synchronizer flop stages per channel (>=2).
- RR, 1'b1, arbitration mode: 1 = round-robin, 0 = fixed priority (lowest index wins).

Ports:
- clk  input  1  clock.
- rst  input  1  reset, asynchronous, active-high.
- clken  input  1  sample enable for the synchronizer, edge detector and pending-set logic. The arbiter and handshake run on every clk.
- cfg_wr  input  1  loads cfg_pos_i and cfg_ena_i on this clk.
- cfg_pos_i  input  NCH  per-channel polarity: 1 = rising edge, 0 = falling edge.
- cfg_ena_i  input  NCH  per-channel enable.
- in  input  NCH  asynchronous event inputs.
- evt_valid  output  1  an event is offered.
- evt_chan  output  clog2(NCH)  channel of the offered event.
- evt_ack  input  1  consumer accepts the offered event.
- pend  output  NCH  pending-event bits.
- ovfl  output  NCH  sticky overflow bits.
- ovfl_clr  input  1  clears all ovfl bits.

Behaviour:
- **Reset values:** evt_valid=0, evt_chan=0, pend=0, ovfl=0, cfg_pos=all 1, cfg_ena=all 0. Synchronizer and last-sample registers are 0. Round-robin pointer is 0.
- **Synchronizer:** SYNC flops per channel, shifting on clk only when clken=1. The output is s.
- **Edge detection:** a last register captures s when clken=1.
  - edge[n] = clken & ena[n] & (pos[n] ? s & ~last : ~s & last).
  - Polarity changes do not create edges. Edges depend only on s and last.
- **Latency:** with clken held at 1, an input transition asserts pend SYNC+1 clks later. evt_valid asserts on the following clk if the arbiter is idle.
- **Pending set and overflow:** edge sets pend[n]. If pend[n] is already 1 and the event is not being acked this cycle, ovfl[n] is set.
- **Configuration:** cfg_wr updates the configuration registers. Clearing ena[n] clears pend[n] on the same clk, unless channel n is currently offered; an offered event stays until acked. ovfl is unaffected by disabling a channel.
- **ovfl_clr:** clears all ovfl bits. A simultaneous overflow set on a channel wins for that channel.
- **FSM IDLE:**
  - If pend != 0, select a channel and go to OFFER next clk with evt_valid=1 and evt_chan=selected.
  - RR=1: select the first pending channel at or above the pointer, wrapping from NCH-1 to 0.
  - RR=0: select the lowest pending index.
- **FSM OFFER:**
  - evt_valid=1 and evt_chan are held stable until evt_ack.
  - On evt_ack: clear pend[evt_chan] and return to IDLE. In RR mode the pointer becomes evt_chan+1, modulo NCH.
  - If an edge on evt_chan coincides with the ack, pend stays 1 and no overflow is flagged.
  - Minimum spacing between offers is 2 clk (OFFER to IDLE to OFFER). evt_valid drops for one clk between events.
- **Handshake edge cases:** evt_ack while evt_valid=0 is ignored. Pend bits for other channels keep setting during OFFER.
- **Reset mid-operation:** all state returns to reset values immediately. Offered and pending events are discarded.
- **Power-up edge:** an input held high through reset on an enabled rising-edge channel yields exactly one event after reset, because last resets to 0.

Test Plan:
- **Single event:** cfg_ena=0x01, cfg_pos=0x01, clken=1. Raise in[0] at clk 0. Expect pend[0]=1 at clk 3 and evt_valid=1 with evt_chan=0 at clk 4. Ack at clk 6 gives pend=0 and evt_valid=0 at clk 7.
- **Falling polarity:** cfg_pos[3]=0, ena[3]=1. A rising in[3] gives no event. The subsequent fall gives exactly one event on channel 3. With clken=0 held, no edge is detected and pend stays 0.
- **Round-robin:** RR=1, ena=0xFF. Edges on channels 2, 5 and 7 occur simultaneously. Expect offers in order 2, 5, 7. New edges on 2 and 7 after 5 is acked are offered in order 7, 2.
- **Fixed priority:** RR=0. Channels 6 and 1 are pending. Expect offer 1, then 6. If channel 0 becomes pending during the offer of 1, expect offer 0 before 6.
- **Overflow:** a second edge on channel 4 before ack sets ovfl[4]=1 while pend[4] stays 1. An edge coinciding with the ack leaves pend[4]=1 and ovfl[4]=0. ovfl_clr clears ovfl; a same-cycle overflow keeps the bit at 1.
- **Reset and disable:** asserting rst during OFFER gives evt_valid=0 and pend=0 asynchronously. Disabling a non-offered pending channel clears its pend. Disabling the offered channel keeps evt_valid=1 until ack.
